wc_tile_feeder: RTL

- Upstream neighbour of the Winograd F(3,4) core.
- Accepts a serial stream of signed 10-bit samples, one per handshake.
- Emits overlapping 6-sample input tiles with stride 3, packed in the core's D-bus format (element 0 in the MSBs). Each tile yields 3 outputs.
- Handles end-of-row flush with zero padding and valid/ready backpressure on both sides.

---
 rtl/wc_tile_feeder.sv | 119 +++++++++++
 1 files changed

// File: rtl/wc_tile_feeder.sv
// Tile feeder for the Winograd F(3,4) core: turns a serial sample stream into
// overlapping 6-sample tiles (stride 3), zero-padding the tail of each row.
module wc_tile_feeder #(
  parameter int DW     = 10,
  parameter int TILE   = 6,
  parameter int STRIDE = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DW-1:0]        s_data,
  input  logic                 s_valid,
  input  logic                 s_last,
  output logic                 s_ready,
  output logic [TILE*DW-1:0]   t_data,
  output logic                 t_valid,
  output logic                 t_last,
  input  logic                 t_ready,
  output logic [15:0]          tile_cnt
);

  localparam int NW = $clog2(TILE + 1);
  localparam logic [NW-1:0] NEED_FULL = NW'(TILE);
  localparam logic [NW-1:0] NEED_STEP = NW'(STRIDE);
  localparam logic [NW-1:0] NEED_ONE  = NW'(1);

  typedef enum logic [1:0] {
    ST_FILL,
    ST_PAD,
    ST_EMIT
  } state_e;

  state_e          state_q, state_d;
  logic [DW-1:0]   win_q [TILE];
  logic [DW-1:0]   win_d [TILE];
  logic [NW-1:0]   need_q, need_d;
  logic            last_seen_q, last_seen_d;
  logic [15:0]     tile_cnt_q, tile_cnt_d;
  logic            accept;

  // Gating with rst keeps s_ready low for the whole reset, not just until the first edge.
  assign s_ready = rst && (state_q == ST_FILL);
  assign accept  = s_valid && s_ready;

  // NOTE: every variable written here gets a default first so no path infers a latch.
  always_comb begin
    state_d     = state_q;
    need_d      = need_q;
    last_seen_d = last_seen_q;
    tile_cnt_d  = tile_cnt_q;
    for (int i = 0; i < TILE; i++) win_d[i] = win_q[i];

    unique case (state_q)
      ST_FILL: begin
        if (accept) begin
          for (int i = 0; i < TILE - 1; i++) win_d[i] = win_q[i+1];
          win_d[TILE-1] = s_data;
          need_d        = need_q - NEED_ONE;
          if (s_last) last_seen_d = 1'b1;
          // A row ending exactly on a full window skips padding.
          if (need_q == NEED_ONE) state_d = ST_EMIT;
          else if (s_last)        state_d = ST_PAD;
        end
      end

      ST_PAD: begin
        for (int i = 0; i < TILE - 1; i++) win_d[i] = win_q[i+1];
        win_d[TILE-1] = '0;
        need_d        = need_q - NEED_ONE;
        if (need_q == NEED_ONE) state_d = ST_EMIT;
      end

      ST_EMIT: begin
        if (t_ready) begin
          tile_cnt_d = tile_cnt_q + 16'd1;
          state_d    = ST_FILL;
          if (last_seen_q) begin
            for (int i = 0; i < TILE; i++) win_d[i] = '0;
            need_d      = NEED_FULL;
            last_seen_d = 1'b0;
          end else begin
            // Overlap: the trailing samples slide to the front over the next shifts.
            need_d = NEED_STEP;
          end
        end
      end

      default: state_d = ST_FILL;
    endcase
  end

  // NOTE: the window is reset explicitly; padding and the first tile after reset
  // rely on it holding zeros, so it cannot be left as an unreset memory.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_FILL;
      need_q      <= NEED_FULL;
      last_seen_q <= 1'b0;
      tile_cnt_q  <= '0;
      for (int i = 0; i < TILE; i++) win_q[i] <= '0;
    end else begin
      // NOTE: non-blocking assignments so all state updates see pre-edge values.
      state_q     <= state_d;
      need_q      <= need_d;
      last_seen_q <= last_seen_d;
      tile_cnt_q  <= tile_cnt_d;
      for (int i = 0; i < TILE; i++) win_q[i] <= win_d[i];
    end
  end

  always_comb begin
    t_data = '0;
    for (int i = 0; i < TILE; i++) t_data[(TILE-1-i)*DW +: DW] = win_q[i];
  end

  assign t_valid  = (state_q == ST_EMIT);
  assign t_last   = t_valid && last_seen_q;
  assign tile_cnt = tile_cnt_q;

endmodule
